// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared types and constants for the time-multiplexed FIR
//            sequencer (fir_mac_seq) and its narrowing stage (fir_sat_acc).
// Contents : state_t     - sequencer state (IDLE / MAC / OUT)
//            FRAC_BITS   - Q1.15 fractional bit count
//            ROUND_CONST - half-LSB added before the shift when rounding
//            SAT_MAX/MIN - Q1.15 clip values
// Options  : FIR_ROUND_EN (consumed by fir_sat_acc)
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam int          FRAC_BITS   = 15;
   localparam int          ROUND_CONST = 1 << 14;
   localparam logic [15:0] SAT_MAX     = 16'h7FFF;
   localparam logic [15:0] SAT_MIN     = 16'h8000;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_sat_acc.sv
`default_nettype none
// ============================================================================
// Module   : fir_sat_acc
// Purpose  : Combinational narrowing of the MAC accumulator to a Q1.15
//            result: optional round-half-up, arithmetic shift by FRAC_BITS,
//            clip to the signed DATA_WIDTH range and flag the clip.
// Ports    : i_acc  [ACC_WIDTH]  signed accumulator value
//            o_data [DATA_WIDTH] narrowed (possibly clipped) result
//            o_sat               result was clipped
// Options  : FIR_ROUND_EN defined -> add ROUND_CONST before the shift,
//            otherwise plain truncation toward minus infinity.
// Revision : 1.0 - initial release
// ============================================================================
module fir_sat_acc
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 40
) (
   input  logic signed [ACC_WIDTH-1:0]  i_acc,
   output logic        [DATA_WIDTH-1:0] o_data,
   output logic                         o_sat
);

   // One guard bit so the rounding add can never wrap.
   logic signed [ACC_WIDTH:0]             w_sum;
   logic signed [ACC_WIDTH:0]             w_shifted;
   // Bits from the result sign bit upward; all equal <=> value fits.
   logic        [ACC_WIDTH-DATA_WIDTH+1:0] w_hi;

   always_comb begin
      w_sum = {i_acc[ACC_WIDTH-1], i_acc};
`ifdef FIR_ROUND_EN
      w_sum = w_sum + (ACC_WIDTH+1)'(ROUND_CONST);
`endif
      w_shifted = w_sum >>> FRAC_BITS;
      w_hi      = w_shifted[ACC_WIDTH:DATA_WIDTH-1];

      if ((&w_hi) || !(|w_hi)) begin
         o_data = w_shifted[DATA_WIDTH-1:0];
         o_sat  = 1'b0;
      end else if (w_shifted[ACC_WIDTH]) begin
         o_data = DATA_WIDTH'(SAT_MIN);
         o_sat  = 1'b1;
      end else begin
         o_data = DATA_WIDTH'(SAT_MAX);
         o_sat  = 1'b1;
      end
   end

endmodule : fir_sat_acc
`default_nettype wire

// File: rtl/fir_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_seq
// Purpose  : Time-multiplexed FIR. Accepts one sample per valid/ready
//            handshake into a circular delay line, then runs one shared MAC
//            over all NTAPS taps (one tap per cycle) and presents the
//            saturated Q1.15 result on a valid/ready output.
// Ports    : clk, rst_n                 clock, async active-low reset
//            in_valid/in_ready/in_data  sample input handshake
//            out_valid/out_ready        result output handshake
//            out_data, out_sat          result and clip flag
//            cfg_we/cfg_addr/cfg_data   coefficient write (IDLE only)
//            cfg_err                    one-cycle pulse on a dropped write
// Options  : FIR_ROUND_EN - round half up before narrowing (fir_sat_acc).
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_seq
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NTAPS      = 16,
   parameter int ACC_WIDTH  = 40
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_WIDTH-1:0]         in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_sat,
   input  logic                          cfg_we,
   input  logic [$clog2(NTAPS)-1:0]      cfg_addr,
   input  logic [DATA_WIDTH-1:0]         cfg_data,
   output logic                          cfg_err
);

   localparam int AW = $clog2(NTAPS);
   localparam int PW = 2 * DATA_WIDTH;

   state_t                        state_q,    state_d;
   logic [AW-1:0]                 wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]                 base_q,     base_d;
   logic [AW-1:0]                 k_q,        k_d;
   logic signed [ACC_WIDTH-1:0]   acc_q,      acc_d;
   logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
   logic                          out_sat_q,  out_sat_d;
   logic                          cfg_err_q,  cfg_err_d;
   logic signed [DATA_WIDTH-1:0]  x_q [NTAPS];
   logic signed [DATA_WIDTH-1:0]  x_d [NTAPS];
   logic signed [DATA_WIDTH-1:0]  c_q [NTAPS];
   logic signed [DATA_WIDTH-1:0]  c_d [NTAPS];

   logic [AW-1:0]                 rd_idx;
   logic signed [PW-1:0]          coef_ext, samp_ext, prod;
   logic signed [ACC_WIDTH-1:0]   acc_sum;
   logic [DATA_WIDTH-1:0]         nar_data;
   logic                          nar_sat;

   // Newest sample sits at base; older ones walk backwards and the
   // subtraction wraps at AW bits, giving the circular index for free.
   assign rd_idx   = base_q - k_q;
   assign coef_ext = {{DATA_WIDTH{c_q[k_q][DATA_WIDTH-1]}}, c_q[k_q]};
   assign samp_ext = {{DATA_WIDTH{x_q[rd_idx][DATA_WIDTH-1]}}, x_q[rd_idx]};
   assign prod     = coef_ext * samp_ext;
   assign acc_sum  = acc_q + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

   // The last tap's product is folded in before narrowing so the result
   // can be registered on the same edge that ends the MAC phase.
   fir_sat_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_sat (
      .i_acc  (acc_sum),
      .o_data (nar_data),
      .o_sat  (nar_sat)
   );

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      base_d     = base_q;
      k_d        = k_q;
      acc_d      = acc_q;
      out_data_d = out_data_q;
      out_sat_d  = out_sat_q;
      cfg_err_d  = 1'b0;
      x_d        = x_q;
      c_d        = c_q;

      case (state_q)
         IDLE: begin
            // A write coinciding with an accept lands before tap 0 is read.
            if (cfg_we) c_d[cfg_addr] = cfg_data;
            if (in_valid) begin
               x_d[wr_ptr_q] = in_data;
               base_d        = wr_ptr_q;
               wr_ptr_d      = wr_ptr_q + AW'(1);
               acc_d         = '0;
               k_d           = '0;
               state_d       = MAC;
            end
         end
         MAC: begin
            cfg_err_d = cfg_we;
            acc_d     = acc_sum;
            k_d       = k_q + AW'(1);
            if (k_q == AW'(NTAPS - 1)) begin
               out_data_d = nar_data;
               out_sat_d  = nar_sat;
               state_d    = OUT;
            end
         end
         OUT: begin
            cfg_err_d = cfg_we;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         base_q     <= '0;
         k_q        <= '0;
         acc_q      <= '0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
         cfg_err_q  <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            x_q[i] <= '0;
            c_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         base_q     <= base_d;
         k_q        <= k_d;
         acc_q      <= acc_d;
         out_data_q <= out_data_d;
         out_sat_q  <= out_sat_d;
         cfg_err_q  <= cfg_err_d;
         x_q        <= x_d;
         c_q        <= c_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUT);
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign cfg_err   = cfg_err_q;

endmodule : fir_mac_seq
`default_nettype wire

// File: tb/tb_fir_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_seq
// Purpose  : Self-checking bench for fir_mac_seq (NTAPS = 4). Directed
//            scenarios (impulse, clipping, backpressure, busy config write,
//            reset mid-MAC) followed by randomized samples/coefficients, all
//            checked against a convolution model over the sample history.
// Options  : honours FIR_ROUND_EN in the reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_seq;

   localparam int NTAPS = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready, out_sat;
   logic          cfg_we, cfg_err;
   logic [15:0]   in_data, out_data, cfg_data;
   logic [AW-1:0] cfg_addr;

   int total = 0;
   int bad   = 0;

   // Reference state: coefficient values and every sample since reset.
   int coef [NTAPS];
   int hist [$];

   fir_mac_seq #(
      .DATA_WIDTH (16),
      .NTAPS      (NTAPS),
      .ACC_WIDTH  (40)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // y[n] = sum_k c[k] * x[n-k], then Q1.15 narrowing with clipping.
   function automatic void model(output logic [15:0] y, output logic s);
      longint acc = 0;
      longint sh;
      int     n = hist.size();
      for (int k = 0; k < NTAPS; k++)
         if (n - 1 - k >= 0) acc += longint'(coef[k]) * longint'(hist[n - 1 - k]);
`ifdef FIR_ROUND_EN
      acc += 16384;
`endif
      sh = acc >>> 15;
      if (sh > 32767)       begin y = 16'h7FFF; s = 1'b1; end
      else if (sh < -32768) begin y = 16'h8000; s = 1'b1; end
      else                  begin y = sh[15:0]; s = 1'b0; end
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      hist.delete();
      for (int i = 0; i < NTAPS; i++) coef[i] = 0;
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data",  {16'd0, out_data},  32'd0);
      chk("rst_out_sat",   {31'd0, out_sat},   32'd0);
      chk("rst_cfg_err",   {31'd0, cfg_err},   32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic write_coef(input logic [AW-1:0] a, input logic [15:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      coef[a] = int'($signed(d));
      @(posedge clk); #1;
      cfg_we = 1'b0;
      chk("idle_cfg_err", {31'd0, cfg_err}, 32'd0);
   endtask

   task automatic load_coefs(input logic [15:0] c0, c1, c2, c3);
      write_coef(2'd0, c0); write_coef(2'd1, c1);
      write_coef(2'd2, c2); write_coef(2'd3, c3);
   endtask

   // Feed one sample, check latency and result, apply `hold` cycles of
   // backpressure (with a junk in_valid asserted), then release.
   task automatic send(input logic [15:0] d, input int hold, input bit busy_cfg,
                       input bit cfg_same, input logic [AW-1:0] ca, input logic [15:0] cd);
      logic [15:0] ey;
      logic        es;
      int          n;
      in_valid = 1'b1; in_data = d;
      if (cfg_same) begin
         cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
         coef[ca] = int'($signed(cd));
      end
      chk("pre_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; cfg_we = 1'b0;
      hist.push_back(int'($signed(d)));
      model(ey, es);
      chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
      if (busy_cfg) begin
         cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 16'h1234;
      end
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
         if (busy_cfg && n == 1) begin
            cfg_we = 1'b0;
            chk("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
         end
         if (busy_cfg && n == 2) chk("cfg_err_clear", {31'd0, cfg_err}, 32'd0);
      end
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("latency", n, NTAPS);
      chk("out_data", {16'd0, out_data}, {16'd0, ey});
      chk("out_sat", {31'd0, out_sat}, {31'd0, es});
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; in_data = 16'h5A5A;
         @(posedge clk); #1;
         chk("hold_data",      {16'd0, out_data},  {16'd0, ey});
         chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      chk("rel_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rel_in_ready",  {31'd0, in_ready},  32'd1);
   endtask

   initial begin
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      @(posedge clk); #1;
      do_reset();

      // Impulse response
      load_coefs(16'h4000, 16'h2000, 16'h1000, 16'h0800);
      send(16'h7FFF, 0, 0, 0, 0, 0);
      send(16'h0000, 0, 0, 0, 0, 0);
      send(16'h0000, 0, 0, 0, 0, 0);
      send(16'h0000, 0, 0, 0, 0, 0);

      // Positive and negative clipping
      do_reset();
      load_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      for (int i = 0; i < 4; i++) send(16'h7FFF, 0, 0, 0, 0, 0);
      do_reset();
      load_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      for (int i = 0; i < 4; i++) send(16'h8000, 0, 0, 0, 0, 0);

      // Backpressure, then busy config write leaving the impulse unchanged
      send(16'h4000, 5, 0, 0, 0, 0);
      do_reset();
      load_coefs(16'h4000, 16'h2000, 16'h1000, 16'h0800);
      send(16'h7FFF, 0, 1, 0, 0, 0);
      send(16'h0000, 0, 0, 0, 0, 0);
      send(16'h0000, 0, 0, 0, 0, 0);
      send(16'h0000, 0, 0, 0, 0, 0);

      // Reset two edges into MAC
      in_valid = 1'b1; in_data = 16'h1234;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
      hist.delete();
      for (int i = 0; i < NTAPS; i++) coef[i] = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      load_coefs(16'h4000, 16'h2000, 16'h1000, 16'h0800);
      send(16'h7FFF, 0, 0, 0, 0, 0);
      send(16'h0000, 0, 0, 0, 0, 0);
      send(16'h0000, 0, 0, 0, 0, 0);
      send(16'h0000, 0, 0, 0, 0, 0);

      // Randomized coefficients and samples, occasional write-with-accept
      for (int b = 0; b < 3; b++) begin
         do_reset();
         load_coefs(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         for (int i = 0; i < 12; i++) begin
            send(16'($urandom), int'($urandom_range(0, 3)), 0,
                 ($urandom_range(0, 3) == 0), 2'($urandom), 16'($urandom));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fir_mac_seq
`default_nettype wire

// File: doc/fir_mac_seq.md
# fir_mac_seq

Time-multiplexed FIR sequencer. It accepts one 16-bit sample at a time over a valid/ready handshake and stores it in a circular delay line. It then drives a single shared multiply-accumulate unit across all NTAPS taps, one tap per cycle, and emits the result saturated to 16 bits on a valid/ready output. Coefficients are written through a simple configuration port, and the block sits between the sample source and the downstream filter consumer.

## Interface
- `DATA_WIDTH`, 16 (from `DATA_WIDTH` in sys_defs.vh): sample, coefficient and output width.
- `NTAPS`, 16: tap count; power of two, 2..64.
- `ACC_WIDTH`, 40: accumulator width; must be ≥ 2*DATA_WIDTH + log2(NTAPS).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: block can accept a sample.
- `in_data` in DATA_WIDTH: signed Q1.15 sample.
- `out_valid` out 1: filtered result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out DATA_WIDTH: signed Q1.15 saturated result.
- `out_sat` out 1: result was clipped; qualified by `out_valid`.
- `cfg_we` in 1: coefficient write strobe.
- `cfg_addr` in log2(NTAPS): tap index k.
- `cfg_data` in DATA_WIDTH: signed Q1.15 coefficient c[k].
- `cfg_err` out 1: one-cycle pulse when a write is dropped.

## Operation
- FSM states:
  - IDLE → MAC on `in_valid & in_ready`.
  - MAC → OUT after tap NTAPS-1.
  - OUT → IDLE on `out_ready`.
- `in_ready` = (state == IDLE). `out_valid` = (state == OUT).
- Accept: `x[wr_ptr] <= in_data`. Latch `base = wr_ptr`. `wr_ptr <= wr_ptr + 1` (wraps mod NTAPS). Clear `acc`. Set `k = 0`.
- MAC cycle k: `acc += sext(c[k] * x[(base - k) mod NTAPS])`. The product is a full 32-bit signed value. Pointer arithmetic wraps naturally at log2(NTAPS) bits.
- Last MAC cycle: the narrowed result is registered into `out_data`/`out_sat`.
- Narrowing: `s = acc >>> 15` (arithmetic shift).
  - `s > 32767` → 0x7FFF, `out_sat = 1`.
  - `s < -32768` → 0x8000, `out_sat = 1`.
  - Otherwise `s[15:0]`, `out_sat = 0`.
- Coefficient writes are accepted only in IDLE.
  - `cfg_we` in MAC or OUT: write dropped, `cfg_err` pulses the next cycle.
  - `cfg_we` coinciding with an input accept in IDLE is written; it takes effect for that sample.
- `in_valid` outside IDLE is ignored. The source must hold the sample until `in_ready`.
- Reset values:
  - State IDLE, so `in_ready` = 1 once reset is applied.
  - `out_valid` 0, `out_data` 0, `out_sat` 0, `cfg_err` 0.
  - `wr_ptr` 0, `acc` 0; all `x[]` and `c[]` are 0.
- Reset mid-operation aborts immediately. Any pending result is discarded.

## Timing
- Accept at edge T. MAC occupies cycles T+1..T+NTAPS. `out_valid` rises at T+NTAPS+1.
- `out_data` and `out_sat` are stable while `out_valid & !out_ready`.
- With `out_ready` held high: `in_ready` returns at T+NTAPS+2. Maximum throughput is one sample per NTAPS+2 cycles.
- Coefficient write at edge T in IDLE is visible to any MAC starting at T+1 or later.

## Configuration
- `FIR_ROUND_EN` defined: add 2^14 to `acc` before the shift (round half up), then saturate.
- `FIR_ROUND_EN` not defined: plain truncation toward −∞.
- Latency is identical in both builds.

## Structure
- Package `fir_pkg` holds:
  - The state enum (IDLE/MAC/OUT).
  - `FRAC_BITS` = 15 and `ROUND_CONST` = 2^14.
  - `SAT_MAX` = 16'h7FFF and `SAT_MIN` = 16'h8000.
- Sub-module `fir_sat_acc`: combinational ACC_WIDTH → DATA_WIDTH narrowing (shift, optional round, clip, sat flag). It is instantiated once.
- Delay line and coefficient store are flop arrays in the top.

## Test plan
Scenarios 1–3 run with NTAPS = 4.
1. Impulse: c = {0x4000, 0x2000, 0x1000, 0x0800}; feed 0x7FFF, 0, 0, 0.
   - Without rounding → outputs 0x3FFF, 0x1FFF, 0x0FFF, 0x07FF, `out_sat` = 0.
   - With `FIR_ROUND_EN` → 0x4000, 0x2000, 0x1000, 0x0800.
2. Positive clip: all c = 0x7FFF; feed 0x7FFF ×4 → out 1 = 0x7FFE (sat 0); out 4 = 0x7FFF (sat 1).
3. Negative clip: all c = 0x7FFF; feed 0x8000 ×4 → out 1 = 0x8001 (sat 0); out 4 = 0x8000 (sat 1).
4. Backpressure: hold `out_ready` = 0 for 5 cycles after `out_valid`.
   - `out_data` stays constant and `in_ready` stays 0.
   - A held `in_valid` is not taken until the cycle after `out_ready` = 1.
5. Busy config: pulse `cfg_we` (addr 0, data 0x1234) during MAC → `cfg_err` = 1 for one cycle; the following impulse output is unchanged from scenario 1.
6. Reset mid-MAC: assert `rst_n` = 0 at T+2.
   - `out_valid` = 0 and `in_ready` = 1 immediately.
   - After release, reload coefficients and rerun scenario 1 → identical outputs, no residue from the old delay line.
